// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares one sram-like memory port between the instruction-fetch requester
// (inst side) and the load/store requester (data side). Address phases are
// arbitrated with data-side priority plus an anti-starvation override for the
// inst side. A grant that has been presented but not yet accepted is held
// stable until it is accepted or withdrawn. Responses come back in order and
// are routed to their requester through a small FIFO of owner ids.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_sram_*  (in)          inst request: en/wr/size/wen/addr/wdata
//   inst_sram_addr_ok (out)    inst address accepted
//   inst_sram_data_ok (out)    inst response valid, inst_sram_rdata its data
//   data_sram_*                same set of signals for the load/store side
//   mem_* (out)                downstream request, muxed from the grant
//   mem_addr_ok (in)           downstream address accepted
//   mem_data_ok (in)           downstream response valid, mem_rdata its data
//   proto_err (out)            sticky: response arrived with nothing owed
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_en,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(OUTSTANDING);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             owner_q [OUTSTANDING];   // 0 = inst, 1 = data
  logic             owner_d [OUTSTANDING];
  logic [STV_W-1:0] starve_q, starve_d;
  logic             proto_err_q, proto_err_d;

  logic fifo_full, fifo_empty, starved;
  logic req_vld;     // some requester is selected this cycle
  logic req_data;    // selected requester is the data side
  logic mem_accept;  // address handshake completes this cycle
  logic pop;         // a response is consumed this cycle
  logic head;        // owner of the oldest outstanding transaction

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign starved    = (starve_q == STV_LIMIT);
  assign head       = owner_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only; the *_d values
  // are computed with blocking assignments in the combinational blocks below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end

  // NOTE: the owner storage has no reset; an entry is only ever read after it
  // has been written, because the pointers and count are reset.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (arbitration, muxing, handshakes)
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no latch is
  // inferred on paths the case statement does not cover.
  always_comb begin
    req_vld  = 1'b0;
    req_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (starved && inst_sram_en) begin
          req_vld  = 1'b1;
          req_data = 1'b0;
        end else if (data_sram_en) begin
          req_vld  = 1'b1;
          req_data = 1'b1;
        end else if (inst_sram_en) begin
          req_vld  = 1'b1;
          req_data = 1'b0;
        end
      end
      // A held grant ignores priority; withdrawing en drops the request.
      HOLD_I: begin
        req_vld  = inst_sram_en;
        req_data = 1'b0;
      end
      HOLD_D: begin
        req_vld  = data_sram_en;
        req_data = 1'b1;
      end
      default: begin
        req_vld  = 1'b0;
        req_data = 1'b0;
      end
    endcase

    // Full FIFO blocks new address phases but leaves a held grant in place.
    mem_en    = req_vld & ~fifo_full & ~reset;
    mem_wr    = req_data ? data_sram_wr    : inst_sram_wr;
    mem_size  = req_data ? data_sram_size  : inst_sram_size;
    mem_wen   = req_data ? data_sram_wen   : inst_sram_wen;
    mem_addr  = req_data ? data_sram_addr  : inst_sram_addr;
    mem_wdata = req_data ? data_sram_wdata : inst_sram_wdata;

    mem_accept        = mem_en & mem_addr_ok;
    inst_sram_addr_ok = mem_accept & ~req_data;
    data_sram_addr_ok = mem_accept &  req_data;

    // A response belongs only to an entry already in the FIFO, never to the
    // push happening in the same cycle.
    pop               = mem_data_ok & ~fifo_empty & ~reset;
    inst_sram_data_ok = pop & ~head;
    data_sram_data_ok = pop &  head;
    inst_sram_rdata   = mem_rdata;
    data_sram_rdata   = mem_rdata;

    proto_err = proto_err_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_en && !mem_addr_ok) state_d = req_data ? HOLD_D : HOLD_I;
      end
      HOLD_I: begin
        if (mem_accept || !inst_sram_en) state_d = IDLE;
      end
      HOLD_D: begin
        if (mem_accept || !data_sram_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Owner FIFO, starve counter, protocol error
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (mem_accept) begin
      owner_d[wr_ptr_q] = req_data;
      wr_ptr_d          = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({mem_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Count every cycle inst waits; any inst handshake or idle inst clears.
    if (inst_sram_en && !inst_sram_addr_ok) begin
      starve_d = starved ? starve_q : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end

    proto_err_d = proto_err_q | (mem_data_ok & fifo_empty);
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (inst side) and the load/store requester (data side).
- Uses the same en/wr/size/wen/addr/wdata/addr_ok/data_ok/rdata handshake as the pipeline stages on both sides.
- Arbitrates address phases with data-side priority plus an anti-starvation override, holds a grant stable until it is accepted, and routes in-order responses back by tracking owners.
- Sits between the IF/MEM stages and the memory bridge.

Parameters:
OUTSTANDING, 2, max accepted-but-unanswered transactions (owner FIFO depth, >=1)
STARVE_LIMIT, 8, consecutive denied inst cycles before inst wins next arbitration (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_sram_en  in  1  inst request valid
inst_sram_wr  in  1  inst write flag
inst_sram_size  in  2  inst access size
inst_sram_wen  in  4  inst byte enables
inst_sram_addr  in  32  inst address
inst_sram_wdata  in  32  inst write data
inst_sram_addr_ok  out  1  inst address accepted
inst_sram_data_ok  out  1  inst response valid
inst_sram_rdata  out  32  inst read data
data_sram_en, data_sram_wr, data_sram_size, data_sram_wen, data_sram_addr, data_sram_wdata  in  1/1/2/4/32/32  data request, same meaning as inst side
data_sram_addr_ok  out  1  data address accepted
data_sram_data_ok  out  1  data response valid
data_sram_rdata  out  32  data read data
mem_en  out  1  downstream request valid
mem_wr, mem_size, mem_wen, mem_addr, mem_wdata  out  1/2/4/32/32  muxed from the granted requester
mem_addr_ok  in  1  downstream address accepted
mem_data_ok  in  1  downstream response valid
mem_rdata  in  32  downstream read data
proto_err  out  1  sticky: mem_data_ok seen with no outstanding transaction

Behaviour:

Reset values:
- state IDLE; owner FIFO empty; starve counter 0; proto_err 0.
- While reset is high, mem_en, both addr_ok and both data_ok are 0.

Arbitration state machine (IDLE, HOLD_I, HOLD_D):
- mem_en = 0 whenever the owner FIFO is full.
- IDLE, FIFO not full: winner is chosen combinationally.
  - Inst wins if starve_cnt == STARVE_LIMIT and inst_sram_en.
  - Otherwise data wins if data_sram_en.
  - Otherwise inst wins if inst_sram_en.
  - Otherwise no request; mem_en = 0.
- mem_* are driven from the winner the same cycle (zero-latency address path).
- If the winner is presented and mem_addr_ok = 0: next state is HOLD_I or HOLD_D according to the winner.
- HOLD_x: the grant is locked to x regardless of priority. mem_en = x_sram_en, and mem_* follow x.
- HOLD_x -> IDLE on mem_addr_ok, or when x drops its en (request withdrawn).
- Requesters keep request fields stable while en is high and addr_ok is low.
- x_sram_addr_ok = mem_addr_ok & mem_en & (grant == x). Never asserted for the loser.

Owner FIFO:
- Push the winner id (0 = inst, 1 = data) on mem_en & mem_addr_ok.
- Pop on mem_data_ok when not empty.
- Push and pop in the same cycle are both performed; count is unchanged.
- inst_sram_data_ok = mem_data_ok & !empty & head == 0.
- data_sram_data_ok = mem_data_ok & !empty & head == 1.
- mem_rdata is broadcast to both rdata outputs.
- Full (count == OUTSTANDING): no new grant is issued, and HOLD keeps its state but mem_en = 0.
- Read/write pointers wrap modulo OUTSTANDING.

Starve counter:
- Increments, saturating at STARVE_LIMIT, each cycle in which inst_sram_en = 1 and inst is not accepted.
- Clears when inst_sram_en = 0 or when an inst address handshake completes.

Error and same-cycle cases:
- mem_data_ok while the FIFO is empty: the response is dropped, neither data_ok is asserted, and proto_err is set until reset.
- A same-cycle addr_ok and data_ok with an empty FIFO is also an error. A response never belongs to the request accepted in that same cycle.
- Reset mid-transaction discards all outstanding owners. Late mem_data_ok after reset flags proto_err.

Test Plan:
- Only inst_sram_en=1, addr 0xbfc00000, mem_addr_ok=1 -> mem_addr=0xbfc00000, inst_sram_addr_ok=1 same cycle. Next cycle mem_data_ok=1, rdata 0x24080001 -> inst_sram_data_ok=1, inst_sram_rdata=0x24080001, data_sram_data_ok=0.
- Both requesting continuously, mem_addr_ok=1, data_sram_data_ok returns every cycle -> data granted 8 consecutive cycles, inst granted on the 9th, starve counter back to 0.
- Inst granted with mem_addr_ok=0 for 3 cycles while data asserts en -> mem_addr stays at the inst address (HOLD_I) until accepted, then data is granted.
- OUTSTANDING=2: two addresses accepted (inst then data), no data_ok -> mem_en=0 on the third request. Then two data_ok pulses -> inst_sram_data_ok then data_sram_data_ok, in order.
- Push and pop in the same cycle with count=1 -> count stays 1, and the correct owner receives data_ok.
- mem_data_ok=1 with empty FIFO -> no data_ok asserted, proto_err=1 held until reset; reset -> proto_err=0.
